// File: rtl/aurora_tx_fifo.sv
// Transmit buffer in front of the Aurora TX user interface: FWFT FIFO that forwards
// whole packets while the link is up and the far end has not asked for a pause.
module aurora_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int KEEP_W     = DATA_W / 8,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                             rst,
  input  logic                             clk,
  input  logic                             channel_up,
  input  logic                             rem_xoff,
  input  logic                             rem_xon,
  output logic                             fifo_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
  output logic                             tx_paused,
  output logic [15:0]                      drop_cnt,
  input  logic [DATA_W-1:0]                i_tdata,
  input  logic [KEEP_W-1:0]                i_tkeep,
  input  logic                             i_tlast,
  input  logic                             i_tvalid,
  output logic                             i_tready,
  output logic [DATA_W-1:0]                o_tdata,
  output logic [KEEP_W-1:0]                o_tkeep,
  output logic                             o_tlast,
  output logic                             o_tvalid,
  input  logic                             o_tready
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int ENTRY_W = DATA_W + KEEP_W + 1;

  typedef enum logic [1:0] {ST_DOWN, ST_SYNC, ST_RUN} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               mid_pkt_q, mid_pkt_d;
  logic               tx_paused_q, tx_paused_d;
  logic [15:0]        drop_cnt_q, drop_cnt_d;
  logic               fifo_ready_q, fifo_ready_d;
  logic               has_data_q, has_data_d;

  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0] head;
  logic               empty, wr, rd, discard;

  assign head = mem_q[rd_ptr_q];

  // has_data_q keeps the output bus at zero until the first beat is stored.
  assign o_tdata    = has_data_q ? head[ENTRY_W-1 -: DATA_W] : '0;
  assign o_tkeep    = has_data_q ? head[KEEP_W:1] : '0;
  assign o_tlast    = has_data_q & head[0];
  assign fifo_count = count_q;
  assign tx_paused  = tx_paused_q;
  assign drop_cnt   = drop_cnt_q;
  assign fifo_ready = fifo_ready_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    o_tvalid     = 1'b0;
    discard      = 1'b0;
    count_d      = count_q;
    drop_cnt_d   = drop_cnt_q;
    fifo_ready_d = 1'b1;

    empty    = (count_q == '0);
    i_tready = fifo_ready_q & (count_q < CNT_W'(FIFO_DEPTH));
    wr       = i_tvalid & i_tready;

    case (state_q)
      ST_RUN:  o_tvalid = ~empty & (mid_pkt_q | ~tx_paused_q);
      default: discard  = ~empty;
    endcase

    rd         = (o_tvalid & o_tready) | discard;
    mid_pkt_d  = rd ? ~head[0] : mid_pkt_q;
    wr_ptr_d   = wr_ptr_q + PTR_W'(wr);
    rd_ptr_d   = rd_ptr_q + PTR_W'(rd);
    has_data_d = has_data_q | wr;

    case ({wr, rd})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (discard && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;

    // xoff wins over xon when both arrive together.
    if (rem_xoff)     tx_paused_d = 1'b1;
    else if (rem_xon) tx_paused_d = 1'b0;
    else              tx_paused_d = tx_paused_q;

    // Leaving DOWN looks at the open-packet flag after this cycle's discard,
    // so a tail discarded in the same cycle is not waited for twice.
    case (state_q)
      ST_DOWN: if (channel_up) state_d = mid_pkt_d ? ST_SYNC : ST_RUN;
      ST_SYNC: if (discard && head[0]) state_d = ST_RUN;
      default: state_d = state_q;
    endcase
    if (!channel_up) state_d = ST_DOWN;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_DOWN;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      mid_pkt_q    <= 1'b0;
      tx_paused_q  <= 1'b0;
      drop_cnt_q   <= '0;
      fifo_ready_q <= 1'b0;
      has_data_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      mid_pkt_q    <= mid_pkt_d;
      tx_paused_q  <= tx_paused_d;
      drop_cnt_q   <= drop_cnt_d;
      fifo_ready_q <= fifo_ready_d;
      has_data_q   <= has_data_d;
    end
  end

  // NOTE: the storage array has no reset; occupancy is tracked by pointers and count only.
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= {i_tdata, i_tkeep, i_tlast};
  end

endmodule

// File: tb/tb_aurora_tx_fifo.sv
// Randomized bench for aurora_tx_fifo against a queue-based packet model of the
// link behaviour (discard while down, resync to packet boundary, pause between packets).
module tb_aurora_tx_fifo;

  localparam int DATA_W = 8;
  localparam int KEEP_W = 1;
  localparam int DEPTH  = 32;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
  } beat_t;

  logic              rst, clk, channel_up, rem_xoff, rem_xon;
  logic              fifo_ready, tx_paused;
  logic [5:0]        fifo_count;
  logic [15:0]       drop_cnt;
  logic [DATA_W-1:0] i_tdata, o_tdata;
  logic [KEEP_W-1:0] i_tkeep, o_tkeep;
  logic              i_tlast, i_tvalid, i_tready, o_tlast, o_tvalid, o_tready;

  aurora_tx_fifo #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .FIFO_DEPTH(DEPTH)) dut (
    .rst(rst), .clk(clk), .channel_up(channel_up), .rem_xoff(rem_xoff), .rem_xon(rem_xon),
    .fifo_ready(fifo_ready), .fifo_count(fifo_count), .tx_paused(tx_paused), .drop_cnt(drop_cnt),
    .i_tdata(i_tdata), .i_tkeep(i_tkeep), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tkeep(o_tkeep), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a beat queue plus link status.
  beat_t m_q[$];
  bit    m_ready, m_paused, m_open, m_running, m_resync;
  int    m_drops;

  // Stimulus knobs and packet generator.
  int    vprob, rprob, xoff_p, xon_p, flip_pm, fixed_len, limit, accepted, pkt_left;
  beat_t cur;

  function automatic bit exp_itready();
    return m_ready && (m_q.size() < DEPTH);
  endfunction

  function automatic bit exp_ovalid();
    return m_running && (m_q.size() > 0) && (m_open || !m_paused);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_ready = 0; m_paused = 0; m_open = 0; m_running = 0; m_resync = 0; m_drops = 0;
  endtask

  task automatic next_beat();
    if (pkt_left == 0) pkt_left = (fixed_len != 0) ? fixed_len : $urandom_range(1, 6);
    cur.data = DATA_W'($urandom);
    cur.keep = KEEP_W'($urandom);
    pkt_left--;
    cur.last = (pkt_left == 0);
  endtask

  task automatic restart_gen(input int len);
    fixed_len = len;
    pkt_left  = 0;
    next_beat();
  endtask

  task automatic compare();
    check("fifo_ready", 32'(fifo_ready), 32'(m_ready));
    check("i_tready", 32'(i_tready), 32'(exp_itready()));
    check("o_tvalid", 32'(o_tvalid), 32'(exp_ovalid()));
    if (exp_ovalid()) begin
      check("o_tdata", 32'(o_tdata), 32'(m_q[0].data));
      check("o_tkeep", 32'(o_tkeep), 32'(m_q[0].keep));
      check("o_tlast", 32'(o_tlast), 32'(m_q[0].last));
    end
    check("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    check("tx_paused", 32'(tx_paused), 32'(m_paused));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drops));
  endtask

  task automatic model_update();
    bit    wr_m, hs_m, disc_m;
    beat_t b;
    b      = '0;
    wr_m   = i_tvalid && exp_itready();
    hs_m   = exp_ovalid() && o_tready;
    disc_m = !m_running && (m_q.size() > 0);
    if (hs_m || disc_m) begin
      b      = m_q.pop_front();
      m_open = !b.last;
      if (disc_m && m_drops < 65535) m_drops++;
    end
    if (!channel_up) begin
      m_running = 0; m_resync = 0;
    end else if (!m_running) begin
      if (m_resync) begin
        if (disc_m && b.last) begin m_running = 1; m_resync = 0; end
      end else if (m_open) m_resync = 1;
      else m_running = 1;
    end
    if (wr_m) begin
      m_q.push_back('{data: i_tdata, keep: i_tkeep, last: i_tlast});
      accepted++;
      next_beat();
    end
    if (rem_xoff)     m_paused = 1;
    else if (rem_xon) m_paused = 0;
    m_ready = 1;
  endtask

  task automatic drive();
    i_tvalid = (accepted < limit) && ($urandom_range(0, 99) < vprob);
    i_tdata  = cur.data;
    i_tkeep  = cur.keep;
    i_tlast  = cur.last;
    o_tready = $urandom_range(0, 99) < rprob;
    rem_xoff = $urandom_range(0, 99) < xoff_p;
    rem_xon  = $urandom_range(0, 99) < xon_p;
    if (flip_pm > 0 && $urandom_range(0, 999) < flip_pm) channel_up = ~channel_up;
  endtask

  // Called at a falling edge: check, advance one clock, drive new inputs.
  task automatic step();
    compare();
    @(posedge clk);
    model_update();
    #1 drive();
    @(negedge clk);
  endtask

  task automatic run(input int n, input int vp, input int rp, input int xo, input int xn);
    vprob = vp; rprob = rp; xoff_p = xo; xon_p = xn;
    drive();
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1; channel_up = 1'b0; rem_xoff = 1'b0; rem_xon = 1'b0;
    i_tvalid = 1'b0; i_tdata = '0; i_tkeep = '0; i_tlast = 1'b0; o_tready = 1'b0;
    vprob = 0; rprob = 0; xoff_p = 0; xon_p = 0; flip_pm = 0; accepted = 0; limit = 0;
    model_reset();
    restart_gen(4);

    @(negedge clk);
    compare();
    check("rst_o_tdata", 32'(o_tdata), 32'h0);
    check("rst_o_tlast", 32'(o_tlast), 32'h0);
    rst = 1'b0;

    // Basic flow: three 4-beat packets.
    channel_up = 1'b1;
    restart_gen(4);
    limit = accepted + 12;
    run(18, 100, 100, 0, 0);
    check("basic_drop_cnt", 32'(drop_cnt), 32'd0);

    // Full: 40 beats offered with the output stalled, then released.
    restart_gen(4);
    limit = accepted + 40;
    run(45, 100, 0, 0, 0);
    check("full_count", 32'(fifo_count), 32'd32);
    check("full_tready", 32'(i_tready), 32'd0);
    run(60, 100, 100, 0, 0);

    // Pause in the middle of a 6-beat packet.
    restart_gen(6);
    limit = accepted + 12;
    run(2, 100, 100, 0, 0);
    run(1, 100, 100, 100, 0);
    run(15, 100, 100, 0, 0);
    check("pause_flag", 32'(tx_paused), 32'd1);
    check("pause_held", 32'(o_tvalid), 32'd0);
    run(1, 100, 100, 0, 100);
    run(12, 100, 100, 0, 0);

    // Simultaneous xoff and xon.
    run(1, 0, 100, 100, 100);
    vprob = 0; xoff_p = 0; xon_p = 0;
    drive();
    check("both_flag", 32'(tx_paused), 32'd1);
    run(1, 0, 100, 0, 100);
    run(4, 0, 100, 0, 0);

    // Channel down: five beats written and discarded.
    channel_up = 1'b0;
    restart_gen(5);
    limit = accepted + 5;
    run(12, 100, 100, 0, 0);
    check("down_drops", 32'(drop_cnt), 32'd5);
    check("down_count", 32'(fifo_count), 32'd0);

    // Resync: two beats dropped while down, rest of packet dropped after link-up.
    restart_gen(5);
    limit = accepted + 2;
    run(6, 100, 100, 0, 0);
    channel_up = 1'b1;
    limit = accepted + 8;
    run(20, 100, 100, 0, 0);
    check("resync_drops", 32'(drop_cnt), 32'd10);

    // Long randomized run with link flaps and pause traffic.
    flip_pm = 4;
    limit   = 32'h7fff_ffff;
    restart_gen(0);
    run(3000, 70, 60, 3, 5);
    flip_pm = 0;

    // Asynchronous reset in the middle of traffic.
    channel_up = 1'b1;
    run(6, 100, 100, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_ready", 32'(fifo_ready), 32'd0);
    check("arst_tready", 32'(i_tready), 32'd0);
    check("arst_tvalid", 32'(o_tvalid), 32'd0);
    check("arst_count", 32'(fifo_count), 32'd0);
    check("arst_drops", 32'(drop_cnt), 32'd0);
    check("arst_paused", 32'(tx_paused), 32'd0);
    check("arst_tdata", 32'(o_tdata), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    run(30, 80, 80, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
